// File: rtl/next_block_sched.sv
`timescale 1ns/1ps
`default_nettype none
`ifndef TETRIS_COLORS_WIDTH
`define TETRIS_COLORS_WIDTH 3
`endif
`ifndef FIELD_COL_CNT_WIDTH
`define FIELD_COL_CNT_WIDTH 4
`endif
`ifndef FIELD_ROW_CNT_WIDTH
`define FIELD_ROW_CNT_WIDTH 5
`endif
// ============================================================================
// Module      : next_block_sched
// Description : Prefetch queue of upcoming pieces fed by a fixed-latency
//               generator, with one color-repeat reroll per slot.
// Revision    : 1.0 - initial release
// ============================================================================
module next_block_sched #(
    parameter int QUEUE_DEPTH = 3,
    parameter int GEN_LAT     = 3,
    parameter bit REROLL_EN   = 1'b1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    output logic                                   gen_en_o,
    input  logic [63:0]                            gen_data_i,
    input  logic [`TETRIS_COLORS_WIDTH-1:0]        gen_color_i,
    input  logic [1:0]                             gen_rotation_i,
    input  logic signed [`FIELD_COL_CNT_WIDTH:0]   gen_x_i,
    input  logic signed [`FIELD_ROW_CNT_WIDTH:0]   gen_y_i,
    input  logic                                   block_req_i,
    output logic                                   block_valid_o,
    output logic [63:0]                            block_data_o,
    output logic [`TETRIS_COLORS_WIDTH-1:0]        block_color_o,
    output logic [1:0]                             block_rotation_o,
    output logic signed [`FIELD_COL_CNT_WIDTH:0]   block_x_o,
    output logic signed [`FIELD_ROW_CNT_WIDTH:0]   block_y_o,
    output logic [`TETRIS_COLORS_WIDTH-1:0]        preview_color_o,
    output logic [2:0]                             fill_cnt_o
);

    localparam int CW     = `TETRIS_COLORS_WIDTH;
    localparam int XW     = `FIELD_COL_CNT_WIDTH + 1;
    localparam int YW     = `FIELD_ROW_CNT_WIDTH + 1;
    localparam int WAIT_W = $clog2(GEN_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_KICK    = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t              state_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                reroll_q;
    logic                gen_en_q;

    logic [2:0]          fill_q, fill_d;
    logic [1:0]          head_q, head_d;
    logic [1:0]          tail_q, tail_d;

    logic [63:0]         data_q  [QUEUE_DEPTH];
    logic [CW-1:0]       color_q [QUEUE_DEPTH];
    logic [1:0]          rot_q   [QUEUE_DEPTH];
    logic signed [XW-1:0] x_q    [QUEUE_DEPTH];
    logic signed [YW-1:0] y_q    [QUEUE_DEPTH];

    logic                pop;
    logic                push;
    logic                match;
    logic [1:0]          tail_prev;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(QUEUE_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [1:0] ptr_dec(input logic [1:0] p);
        return (p == 2'd0) ? 2'(QUEUE_DEPTH - 1) : p - 2'd1;
    endfunction

    assign block_valid_o = (fill_q != 3'd0);
    assign pop           = block_req_i && block_valid_o;
    assign tail_prev     = ptr_dec(tail_q);
    assign match         = REROLL_EN && !reroll_q && block_valid_o &&
                           (gen_color_i == color_q[tail_prev]);
    assign push          = (state_q == S_CAPTURE) && !match &&
                           ((fill_q < 3'(QUEUE_DEPTH)) || pop);

    always_comb begin
        fill_d = fill_q;
        head_d = head_q;
        tail_d = tail_q;
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        if (push) begin
            tail_d = ptr_inc(tail_q);
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + 3'd1;
            2'b01:   fill_d = fill_q - 3'd1;
            default: fill_d = fill_q;
        endcase
        if (flush_i) begin
            fill_d = 3'd0;
            head_d = 2'd0;
            tail_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_q <= 3'd0;
            head_q <= 2'd0;
            tail_q <= 2'd0;
        end else begin
            fill_q <= fill_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage needs no reset: every read is gated by block_valid_o / fill_q.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && push) begin
            data_q[tail_q]  <= gen_data_i;
            color_q[tail_q] <= gen_color_i;
            rot_q[tail_q]   <= gen_rotation_i;
            x_q[tail_q]     <= gen_x_i;
            y_q[tail_q]     <= gen_y_i;
        end
    end

    // The wait counter already runs during KICK, so CAPTURE lands GEN_LAT cycles after the pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            reroll_q <= 1'b0;
            gen_en_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fill_q < 3'(QUEUE_DEPTH)) begin
                        state_q  <= S_KICK;
                        gen_en_q <= 1'b1;
                        wait_q   <= WAIT_W'(GEN_LAT - 1);
                    end
                end
                S_KICK: begin
                    gen_en_q <= 1'b0;
                    if (wait_q == '0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        wait_q  <= wait_q - 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (match) begin
                        reroll_q <= 1'b1;
                        state_q  <= S_KICK;
                        gen_en_q <= 1'b1;
                        wait_q   <= WAIT_W'(GEN_LAT - 1);
                    end else begin
                        reroll_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gen_en_o         = gen_en_q;
    assign fill_cnt_o       = fill_q;
    assign block_data_o     = block_valid_o ? data_q[head_q]  : '0;
    assign block_color_o    = block_valid_o ? color_q[head_q] : '0;
    assign block_rotation_o = block_valid_o ? rot_q[head_q]   : '0;
    assign block_x_o        = block_valid_o ? x_q[head_q]     : '0;
    assign block_y_o        = block_valid_o ? y_q[head_q]     : '0;
    assign preview_color_o  = (fill_q >= 3'd2) ? color_q[ptr_inc(head_q)] : '0;

endmodule
`default_nettype wire

// File: tb/tb_next_block_sched.sv
`timescale 1ns/1ps
`default_nettype none
`ifndef TETRIS_COLORS_WIDTH
`define TETRIS_COLORS_WIDTH 3
`endif
`ifndef FIELD_COL_CNT_WIDTH
`define FIELD_COL_CNT_WIDTH 4
`endif
`ifndef FIELD_ROW_CNT_WIDTH
`define FIELD_ROW_CNT_WIDTH 5
`endif
// ============================================================================
// Module      : tb_next_block_sched
// Description : Directed bench with a latency-3 generator model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_next_block_sched;

    localparam int CW = `TETRIS_COLORS_WIDTH;
    localparam int XW = `FIELD_COL_CNT_WIDTH + 1;
    localparam int YW = `FIELD_ROW_CNT_WIDTH + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, flush, req;
    logic                 gen_en;
    logic [63:0]          gen_data  = '0;
    logic [CW-1:0]        gen_color = '0;
    logic [1:0]           gen_rot   = '0;
    logic signed [XW-1:0] gen_x     = '0;
    logic signed [YW-1:0] gen_y     = '0;
    logic                 valid;
    logic [63:0]          b_data;
    logic [CW-1:0]        b_color;
    logic [1:0]           b_rot;
    logic signed [XW-1:0] b_x;
    logic signed [YW-1:0] b_y;
    logic [CW-1:0]        preview;
    logic [2:0]           fill;

    int checks = 0;
    int errors = 0;

    next_block_sched #(.QUEUE_DEPTH(3), .GEN_LAT(3), .REROLL_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .gen_en_o(gen_en),
        .gen_data_i(gen_data), .gen_color_i(gen_color), .gen_rotation_i(gen_rot),
        .gen_x_i(gen_x), .gen_y_i(gen_y), .block_req_i(req),
        .block_valid_o(valid), .block_data_o(b_data), .block_color_o(b_color),
        .block_rotation_o(b_rot), .block_x_o(b_x), .block_y_o(b_y),
        .preview_color_o(preview), .fill_cnt_o(fill)
    );

    // Generator model: piece index advances per pulse, fields appear 3 cycles later.
    logic [CW-1:0] color_seq [0:255];
    int   gen_idx = 0;
    logic s1_v = 1'b0, s2_v = 1'b0;
    int   s1_idx = 0, s2_idx = 0;

    function automatic logic [63:0] piece_data(input int i);
        return {32'hB10C_0000 + 32'(i), ~32'(i)};
    endfunction

    always @(posedge clk) begin
        s1_v <= gen_en;
        if (gen_en) begin
            s1_idx  <= gen_idx;
            gen_idx <= gen_idx + 1;
        end
        s2_v   <= s1_v;
        s2_idx <= s1_idx;
        if (s2_v) begin
            gen_color <= color_seq[s2_idx[7:0]];
            gen_data  <= piece_data(s2_idx);
            gen_rot   <= 2'(s2_idx);
            gen_x     <= XW'(s2_idx + 1);
            gen_y     <= YW'(-(s2_idx + 2));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", fill); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
        checks++; if (gen_en !== 1'b0) begin errors++; $display("FAIL reset_gen_en got %0b want 0", gen_en); end
        checks++; if (b_color !== '0 || preview !== '0) begin
            errors++; $display("FAIL reset_colors got %0d/%0d want 0/0", b_color, preview);
        end
        checks++; if (b_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h want 0", b_data); end
        rst = 1'b0;
    endtask

    task automatic test_fill;
        logic [15:0] mask;
        logic signed [YW-1:0] exp_y;
        mask  = '0;
        exp_y = YW'(-2);
        for (int c = 0; c < 16; c++) begin
            mask[c] = gen_en;
            if (c == 14) begin
                checks++; if (fill !== 3'd2) begin errors++; $display("FAIL fill_c14 got %0d want 2", fill); end
            end
            if (c < 15) tick();
        end
        checks++; if (mask !== 16'h0842) begin errors++; $display("FAIL fill_pulses got %h want 0842", mask); end
        checks++; if (fill !== 3'd3) begin errors++; $display("FAIL fill_c15 got %0d want 3", fill); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL fill_valid got %0b want 1", valid); end
        checks++; if (b_color !== 3'd1) begin errors++; $display("FAIL fill_color got %0d want 1", b_color); end
        checks++; if (preview !== 3'd2) begin errors++; $display("FAIL fill_preview got %0d want 2", preview); end
        checks++; if (b_data !== piece_data(0)) begin
            errors++; $display("FAIL fill_data got %h want %h", b_data, piece_data(0));
        end
        checks++; if (b_rot !== 2'd0 || b_x !== XW'(1) || b_y !== exp_y) begin
            errors++; $display("FAIL fill_pos got rot %0d x %0d y %0d want 0 1 -2", b_rot, b_x, b_y);
        end
    endtask

    task automatic test_pop_refill;
        req = 1'b1;
        tick();
        req = 1'b0;
        checks++; if (fill !== 3'd2) begin errors++; $display("FAIL pop_fill got %0d want 2", fill); end
        checks++; if (b_color !== 3'd2) begin errors++; $display("FAIL pop_color got %0d want 2", b_color); end
        checks++; if (preview !== 3'd3) begin errors++; $display("FAIL pop_preview got %0d want 3", preview); end
        tick();
        checks++; if (gen_en !== 1'b1) begin errors++; $display("FAIL pop_kick got %0b want 1", gen_en); end
        repeat (4) tick();
        checks++; if (fill !== 3'd3) begin errors++; $display("FAIL pop_refill got %0d want 3", fill); end
    endtask

    task automatic test_reroll;
        int pulses;
        pulses = 0;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (gen_en === 1'b1) pulses++;
            if (c == 8) begin
                checks++; if (fill !== 3'd2) begin errors++; $display("FAIL reroll_drop got %0d want 2", fill); end
            end
            if (c == 9) begin
                checks++; if (fill !== 3'd3) begin errors++; $display("FAIL reroll_push got %0d want 3", fill); end
            end
            if (c < 19) tick();
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL reroll_pulses got %0d want 2", pulses); end
        checks++; if (b_color !== 3'd3 || preview !== 3'd5) begin
            errors++; $display("FAIL reroll_order got %0d/%0d want 3/5", b_color, preview);
        end
        req = 1'b1;
        tick();
        req = 1'b0;
        checks++; if (b_color !== 3'd5 || preview !== 3'd5 || fill !== 3'd2) begin
            errors++; $display("FAIL reroll_cap got %0d/%0d fill %0d want 5/5 fill 2", b_color, preview, fill);
        end
    endtask

    task automatic test_flush_empty;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (fill !== 3'd0 || valid !== 1'b0) begin
            errors++; $display("FAIL flush_clear got fill %0d valid %0b want 0 0", fill, valid);
        end
        for (int i = 0; i < 3; i++) begin
            req = 1'b1;
            tick();
            checks++; if (valid !== 1'b0 || fill !== 3'd0 || b_color !== '0 || b_data !== 64'd0) begin
                errors++; $display("FAIL empty_req got valid %0b fill %0d color %0d data %h want 0", valid, fill, b_color, b_data);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_flush_wait;
        int n;
        n = 0;
        while (!(gen_en === 1'b1 && fill === 3'd2) && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n >= 40) begin errors++; $display("FAIL fw_timeout got %0d cycles want <40", n); end
        tick();
        flush = 1'b1;
        req   = 1'b1;
        tick();
        flush = 1'b0;
        req   = 1'b0;
        checks++; if (fill !== 3'd0 || valid !== 1'b0 || b_color !== '0) begin
            errors++; $display("FAIL fw_clear got fill %0d valid %0b color %0d want 0", fill, valid, b_color);
        end
        checks++; if (gen_en !== 1'b0) begin errors++; $display("FAIL fw_idle got %0b want 0", gen_en); end
        tick();
        checks++; if (gen_en !== 1'b1) begin errors++; $display("FAIL fw_rekick got %0b want 1", gen_en); end
        tick();
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL fw_no_push got %0d want 0", fill); end
        tick();
        tick();
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL fw_early got %0d want 0", fill); end
        tick();
        checks++; if (fill !== 3'd1) begin errors++; $display("FAIL fw_refill got %0d want 1", fill); end
    endtask

    task automatic test_reset_capture;
        int n;
        n = 0;
        while (!(gen_en === 1'b1 && fill === 3'd2) && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n >= 40) begin errors++; $display("FAIL rc_timeout got %0d cycles want <40", n); end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++; if (fill !== 3'd0 || valid !== 1'b0 || gen_en !== 1'b0) begin
            errors++; $display("FAIL rc_ctrl got fill %0d valid %0b gen_en %0b want 0", fill, valid, gen_en);
        end
        checks++; if (b_color !== '0 || preview !== '0 || b_data !== 64'd0) begin
            errors++; $display("FAIL rc_data got %0d/%0d/%h want 0", b_color, preview, b_data);
        end
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c == 1) begin
                checks++; if (gen_en !== 1'b1) begin errors++; $display("FAIL rc_kick got %0b want 1", gen_en); end
            end
            if (c == 14) begin
                checks++; if (fill !== 3'd2) begin errors++; $display("FAIL rc_c14 got %0d want 2", fill); end
            end
            if (c < 15) tick();
        end
        checks++; if (fill !== 3'd3 || valid !== 1'b1) begin
            errors++; $display("FAIL rc_full got fill %0d valid %0b want 3 1", fill, valid);
        end
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        req   = 1'b0;
        for (int i = 0; i < 256; i++) color_seq[i] = CW'((i % 7) + 1);
        color_seq[3] = 3'd5;
        color_seq[4] = 3'd5;
        color_seq[5] = 3'd5;
        color_seq[6] = 3'd6;
        test_reset();
        test_fill();
        test_pop_refill();
        test_reroll();
        test_flush_empty();
        test_flush_wait();
        test_reset_capture();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
